// File: rtl/irq_event_controller.sv
// Interrupt aggregator: per-source level/rising-edge latching, masking, lowest-index active ID.
// Optional IRQ_COUNT_EN adds a saturating event counter at word address 5.
module irq_event_controller #(
  parameter int unsigned N_IRQ       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [15:0]      writedata,
  output logic [15:0]      readdata,
  input  logic [N_IRQ-1:0] irq_in,
  output logic             irq_out
);

  logic [N_IRQ-1:0] s, rise, w1c, ack, to_edge, pend_en;
  logic [N_IRQ-1:0] prev_q, pending_q, pending_d, enable_q, enable_d, mode_q, mode_d;
  logic             irq_out_q, irq_out_d, wr_en, id_valid;
  logic [3:0]       id;
  logic [15:0]      readdata_q, readdata_d;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = irq_in;
  end else begin : g_sync
    logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [N_IRQ-1:0] sync_d [SYNC_STAGES];

    always_comb begin
      sync_d[0] = irq_in;
      for (int k = 1; k < int'(SYNC_STAGES); k++) sync_d[k] = sync_q[k-1];
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) sync_q <= '{default: '0};
      else       sync_q <= sync_d;
    end

    assign s = sync_q[SYNC_STAGES-1];
  end

  assign rise    = s & ~prev_q;
  assign pend_en = pending_q & enable_q;

  // Lowest pending-and-enabled index wins.
  always_comb begin
    id_valid = 1'b0;
    id       = '0;
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (pend_en[i]) begin
        id_valid = 1'b1;
        id       = 4'(i);
      end
    end
  end

  always_comb begin
    wr_en    = chipselect & ~write_n;
    enable_d = enable_q;
    mode_d   = mode_q;
    w1c      = '0;
    ack      = '0;
    if (wr_en && address == 3'd0) w1c = writedata[N_IRQ-1:0];
    if (wr_en && address == 3'd1) enable_d = writedata[N_IRQ-1:0];
    if (wr_en && address == 3'd2) mode_d = writedata[N_IRQ-1:0];
    if (wr_en && address == 3'd4) begin
      for (int i = 0; i < int'(N_IRQ); i++) begin
        if (writedata[3:0] == 4'(i)) ack[i] = 1'b1;
      end
    end
    to_edge = mode_d & ~mode_q;
    // A fresh rise always beats a clear; a level->edge switch drops the stale level.
    for (int i = 0; i < int'(N_IRQ); i++) begin
      if (to_edge[i])     pending_d[i] = rise[i];
      else if (mode_q[i]) pending_d[i] = rise[i] | (pending_q[i] & ~(w1c[i] | ack[i]));
      else                pending_d[i] = s[i];
    end
    irq_out_d = |pend_en;
  end

`ifdef IRQ_COUNT_EN
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (wr_en && address == 3'd5)                          count_d = '0;
    else if ((|(rise & mode_q & enable_q)) && count_q != 16'hFFFF) count_d = count_q + 16'd1;
  end
`endif

  always_comb begin
    case (address)
      3'd0:    readdata_d = 16'(pending_q);
      3'd1:    readdata_d = 16'(enable_q);
      3'd2:    readdata_d = 16'(mode_q);
      3'd3:    readdata_d = {id_valid, 11'b0, id};
`ifdef IRQ_COUNT_EN
      3'd5:    readdata_d = count_q;
`endif
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q     <= '0;
      pending_q  <= '0;
      enable_q   <= '0;
      mode_q     <= '0;
      irq_out_q  <= 1'b0;
      readdata_q <= '0;
`ifdef IRQ_COUNT_EN
      count_q    <= '0;
`endif
    end else begin
      prev_q     <= s;
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      mode_q     <= mode_d;
      irq_out_q  <= irq_out_d;
      readdata_q <= readdata_d;
`ifdef IRQ_COUNT_EN
      count_q    <= count_d;
`endif
    end
  end

  assign readdata = readdata_q;
  assign irq_out  = irq_out_q;

endmodule

// File: tb/tb_irq_event_controller.sv
// Scoreboard bench for irq_event_controller (N_IRQ=8, SYNC_STAGES=2); stimulus queues
// expectations, a monitor pops and compares when the sample strobe is presented.
module tb_irq_event_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = '0;
  logic [15:0] readdata;
  logic [7:0]  irq_in = '0;
  logic        irq_out;

  typedef struct {
    string       name;
    bit          crd;
    logic [15:0] rd;
    bit          cirq;
    logic        irq;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;
  bit   chk_req = 1'b0;
  bit   chk_vld = 1'b0;
  bit   chk_now = 1'b0;

  irq_event_controller #(.N_IRQ(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .irq_in(irq_in), .irq_out(irq_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) chk_vld <= chk_req;

  // Monitor: one expectation per presented sample.
  always @(negedge clk or posedge chk_now) begin
    if (chk_vld || chk_now) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL scoreboard_underflow: sample presented with no expectation queued");
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.crd) begin
          n_total++;
          if (readdata === e.rd) n_pass++;
          else $display("FAIL %s: readdata=0x%04h expected 0x%04h", e.name, readdata, e.rd);
        end
        if (e.cirq) begin
          n_total++;
          if (irq_out === e.irq) n_pass++;
          else $display("FAIL %s: irq_out=%b expected %b", e.name, irq_out, e.irq);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    chk_req    = 1'b0;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
  endtask

  task automatic push(input string nm, input bit crd, input logic [15:0] erd,
                      input bit cirq, input logic eirq);
    exp_t e;
    e.name = nm; e.crd = crd; e.rd = erd; e.cirq = cirq; e.irq = eirq;
    q.push_back(e);
    chk_req = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] erd, input string nm);
    address = a;
    push(nm, 1'b1, erd, 1'b0, 1'b0);
    step();
  endtask

  task automatic rdi(input logic [2:0] a, input logic [15:0] erd, input logic eirq,
                     input string nm);
    address = a;
    push(nm, 1'b1, erd, 1'b1, eirq);
    step();
  endtask

  task automatic chk_irq(input logic eirq, input string nm);
    push(nm, 1'b0, 16'h0, 1'b1, eirq);
    step();
  endtask

  initial begin
    steps(2);
    reset = 1'b0;
    step();
    rdi(3'd0, 16'h0000, 1'b0, "reset_pending");
    rd(3'd1, 16'h0000, "reset_enable");
    rd(3'd2, 16'h0000, "reset_mode");
    rd(3'd3, 16'h0000, "reset_active_id");

    // Mid-run reset with all eight level sources pending.
    wr(3'd1, 16'h00FF);
    irq_in = 8'hFF;
    steps(4);
    rdi(3'd0, 16'h00FF, 1'b1, "pending_all_level");
    address = 3'd0;
    reset = 1'b1;
    #1;
    push("async_reset", 1'b1, 16'h0000, 1'b1, 1'b0);
    chk_now = 1'b1;
    #1;
    chk_now = 1'b0;
    chk_req = 1'b0;
    irq_in  = '0;
    steps(2);
    reset = 1'b0;
    step();
    rdi(3'd0, 16'h0000, 1'b0, "post_reset_pending");
    rd(3'd1, 16'h0000, "post_reset_enable");
    rd(3'd2, 16'h0000, "post_reset_mode");

    // Level source 0: latency SYNC_STAGES+2 both ways.
    wr(3'd1, 16'h0001);
    irq_in[0] = 1'b1;
    steps(2);
    chk_irq(1'b0, "level_rise_edge3");
    chk_irq(1'b1, "level_rise_edge4");
    rd(3'd3, 16'h8000, "level_active_id");
    irq_in[0] = 1'b0;
    steps(2);
    chk_irq(1'b1, "level_fall_edge3");
    chk_irq(1'b0, "level_fall_edge4");

    // Edge source 2: pulse latches, ACK clears, irq_out low two cycles after.
    wr(3'd2, 16'h0004);
    wr(3'd1, 16'h0004);
    irq_in[2] = 1'b1;
    step();
    irq_in[2] = 1'b0;
    steps(4);
    rdi(3'd0, 16'h0004, 1'b1, "edge_pending");
    rd(3'd3, 16'h8002, "edge_active_id");
    push("ack_edge1", 1'b0, 16'h0, 1'b1, 1'b1);
    wr(3'd4, 16'h0002);
    chk_irq(1'b0, "ack_edge2");
    rd(3'd0, 16'h0000, "ack_pending");

    // Simultaneous edges on 3 and 5.
    wr(3'd2, 16'h0028);
    wr(3'd1, 16'h0028);
    irq_in[3] = 1'b1;
    irq_in[5] = 1'b1;
    steps(4);
    rd(3'd3, 16'h8003, "dual_id3");
    wr(3'd4, 16'h000B);
    rd(3'd3, 16'h8003, "ack_out_of_range");
    wr(3'd4, 16'h0003);
    rd(3'd3, 16'h8005, "dual_id5");
    wr(3'd4, 16'h0005);
    rdi(3'd3, 16'h0000, 1'b0, "dual_none");
    rd(3'd4, 16'h0000, "ack_reads_zero");
    rd(3'd6, 16'h0000, "addr6_zero");
    irq_in[3] = 1'b0;
    irq_in[5] = 1'b0;

    // Level->edge switch drops a held level bit; no rise since prev already high.
    irq_in[1] = 1'b1;
    steps(4);
    rd(3'd0, 16'h0002, "level_src1_pending");
    wr(3'd2, 16'h003A);
    rd(3'd0, 16'h0000, "mode_switch_clears");

    // W1C coinciding with a rise on edge source 4: set wins.
    irq_in[4] = 1'b1;
    steps(2);
    wr(3'd0, 16'h0010);
    rd(3'd0, 16'h0010, "w1c_vs_rise");
    wr(3'd0, 16'h0010);
    rd(3'd0, 16'h0000, "w1c_clears");
    irq_in[4] = 1'b0;
    irq_in[1] = 1'b0;
    steps(3);

`ifdef IRQ_COUNT_EN
    wr(3'd5, 16'h0000);
    rd(3'd5, 16'h0000, "count_cleared");
    repeat (3) begin
      irq_in[3] = 1'b1;
      step();
      irq_in[3] = 1'b0;
      steps(2);
    end
    steps(4);
    rd(3'd5, 16'h0003, "count_three");
    // Sources 3 and 5 toggle out of phase: one enabled-edge rise every cycle.
    for (int c = 0; c < 66000; c++) begin
      @(negedge clk);
      #1;
      irq_in[3] = c[0];
      irq_in[5] = ~c[0];
    end
    irq_in[3] = 1'b0;
    irq_in[5] = 1'b0;
    steps(5);
    rd(3'd5, 16'hFFFF, "count_saturate");
    wr(3'd5, 16'h1234);
    rd(3'd5, 16'h0000, "count_write_clear");
`else
    irq_in[3] = 1'b1;
    steps(4);
    rd(3'd5, 16'h0000, "count_absent");
    irq_in[3] = 1'b0;
`endif

    steps(2);
    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      n_total++;
      $display("FAIL %s: expectation never sampled", e.name);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
